// File: rtl/cmd_scheduler_pkg.sv
// Shared types and command encodings for the DDR4 command scheduler.
// Refresh states are only reachable when CMD_SCHEDULER_REFRESH_EN is defined.
package cmd_scheduler_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PRE,
        WAIT_RP,
        ACT,
        WAIT_RCD,
        RDWR,
        GAP,
        PREA,
        REF,
        WAIT_RFC
    } state_t;

    // {ras_n, cas_n, we_n} carried on A16..A14
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_REF = 3'b001;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bank_row_table.sv
// Open-page tracking: one open bit and one row register per (bank group, bank).
// Exposes any_open only when CMD_SCHEDULER_REFRESH_EN is defined.
module bank_row_table #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BGWIDTH-1:0]   lookup_bg,
    input  logic [BAWIDTH-1:0]   lookup_ba,
    input  logic [ADDRWIDTH-1:0] lookup_row,
    output logic                 lookup_hit,
    output logic                 lookup_open,
    output logic [ADDRWIDTH-1:0] lookup_open_row,
    input  logic [BGWIDTH-1:0]   upd_bg,
    input  logic [BAWIDTH-1:0]   upd_ba,
    input  logic [ADDRWIDTH-1:0] upd_row,
    input  logic                 set_en,
    input  logic                 clear_en,
    input  logic                 clear_all
`ifdef CMD_SCHEDULER_REFRESH_EN
    ,
    output logic                 any_open
`endif
);

    localparam int IW = BGWIDTH + BAWIDTH;
    localparam int NB = 1 << IW;

    logic [NB-1:0]        open_reg;
    logic [ADDRWIDTH-1:0] row_mem [NB];
    logic [IW-1:0]        lookup_idx;
    logic [IW-1:0]        upd_idx;

    assign lookup_idx = {lookup_bg, lookup_ba};
    assign upd_idx    = {upd_bg, upd_ba};

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bank
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    open_reg[gi] <= 1'b0;
                end else if (clear_all) begin
                    open_reg[gi] <= 1'b0;
                end else if (upd_idx == IW'(gi)) begin
                    if (set_en) begin
                        open_reg[gi] <= 1'b1;
                    end else if (clear_en) begin
                        open_reg[gi] <= 1'b0;
                    end
                end
            end

            // Row contents only matter while the open bit is set, so no reset.
            always_ff @(posedge clk) begin
                if (set_en && (upd_idx == IW'(gi))) begin
                    row_mem[gi] <= upd_row;
                end
            end
        end
    endgenerate

    assign lookup_open     = open_reg[lookup_idx];
    assign lookup_open_row = row_mem[lookup_idx];
    assign lookup_hit      = lookup_open && (lookup_open_row == lookup_row);

`ifdef CMD_SCHEDULER_REFRESH_EN
    assign any_open = |open_reg;
`endif

endmodule

// File: rtl/cmd_scheduler.sv
// Single-requester DDR4 command scheduler with open-page policy and MEMSync stall.
// Define CMD_SCHEDULER_REFRESH_EN to add periodic PREA/REF refresh sequencing.
module cmd_scheduler
    import cmd_scheduler_pkg::*;
#(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int TRP       = 4,
    parameter int TRCD      = 4,
    parameter int TCCD      = 4,
    parameter int TREFI     = 3120,
    parameter int TRFC      = 88
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    input  logic                 stall,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic                 rdwr_issued,
    output logic                 rdwr_is_wr
);

    localparam int MAX_BASE = max_int(max_int(TRP, TRCD), TCCD);
`ifdef CMD_SCHEDULER_REFRESH_EN
    localparam int MAX_T = max_int(MAX_BASE, TRFC);
`else
    localparam int MAX_T = MAX_BASE;
`endif
    localparam int CW = $clog2(MAX_T) + 1;

    state_t               state_reg;
    logic [CW-1:0]        cnt_reg;
    logic                 cke_reg;
    logic                 wr_reg;
    logic [BGWIDTH-1:0]   bg_reg;
    logic [BAWIDTH-1:0]   ba_reg;
    logic [ADDRWIDTH-1:0] row_reg;
    logic [COLWIDTH-1:0]  col_reg;

    logic                 lookup_hit;
    logic                 lookup_open;
    logic [ADDRWIDTH-1:0] lookup_open_row;
    logic                 set_en;
    logic                 clear_en;
    logic                 clear_all;
    logic                 refresh_pending;
    logic                 accept;

`ifdef CMD_SCHEDULER_REFRESH_EN
    logic                     any_open;
    logic                     refresh_pending_reg;
    logic                     ref_active_reg;
    logic [$clog2(TREFI)-1:0] ref_cnt_reg;
    assign refresh_pending = refresh_pending_reg;
    assign clear_all       = (state_reg == PREA) && !stall;
`else
    assign refresh_pending = 1'b0;
    assign clear_all       = 1'b0;
`endif

    assign req_ready = (state_reg == IDLE) && !stall && cke_reg && !refresh_pending;
    assign accept    = req_valid && req_ready;
    assign set_en    = (state_reg == ACT) && !stall;
    assign clear_en  = (state_reg == PRE) && !stall;
    assign cke       = cke_reg;

    bank_row_table #(
        .BGWIDTH   (BGWIDTH),
        .BAWIDTH   (BAWIDTH),
        .ADDRWIDTH (ADDRWIDTH)
    ) u_bank_row_table (
        .clk             (clk),
        .reset           (reset),
        .lookup_bg       (req_bg),
        .lookup_ba       (req_ba),
        .lookup_row      (req_row),
        .lookup_hit      (lookup_hit),
        .lookup_open     (lookup_open),
        .lookup_open_row (lookup_open_row),
        .upd_bg          (bg_reg),
        .upd_ba          (ba_reg),
        .upd_row         (row_reg),
        .set_en          (set_en),
        .clear_en        (clear_en),
        .clear_all       (clear_all)
`ifdef CMD_SCHEDULER_REFRESH_EN
        ,
        .any_open        (any_open)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            cke_reg   <= 1'b0;
            wr_reg    <= 1'b0;
            bg_reg    <= '0;
            ba_reg    <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
`ifdef CMD_SCHEDULER_REFRESH_EN
            refresh_pending_reg <= 1'b0;
            ref_active_reg      <= 1'b0;
            ref_cnt_reg         <= '0;
`endif
        end else begin
            cke_reg <= 1'b1;
`ifdef CMD_SCHEDULER_REFRESH_EN
            // Interval counter ignores stall; a wrap mid-refresh is dropped.
            if (ref_cnt_reg == ($clog2(TREFI))'(TREFI - 1)) begin
                ref_cnt_reg <= '0;
                if (!ref_active_reg) begin
                    refresh_pending_reg <= 1'b1;
                end
            end else begin
                ref_cnt_reg <= ref_cnt_reg + 1'b1;
            end
`endif
            if (!stall) begin
                case (state_reg)
                    IDLE: begin
`ifdef CMD_SCHEDULER_REFRESH_EN
                        if (refresh_pending_reg) begin
                            ref_active_reg <= 1'b1;
                            state_reg      <= any_open ? PREA : REF;
                        end else if (accept) begin
`else
                        if (accept) begin
`endif
                            wr_reg  <= req_wr;
                            bg_reg  <= req_bg;
                            ba_reg  <= req_ba;
                            row_reg <= req_row;
                            col_reg <= req_col;
                            if (lookup_open && (lookup_open_row != req_row)) begin
                                state_reg <= PRE;
                            end else if (lookup_hit) begin
                                state_reg <= RDWR;
                            end else begin
                                state_reg <= ACT;
                            end
                        end
                    end
                    PRE: begin
                        cnt_reg   <= CW'(TRP - 2);
                        state_reg <= WAIT_RP;
                    end
                    WAIT_RP: begin
                        if (cnt_reg == '0) begin
`ifdef CMD_SCHEDULER_REFRESH_EN
                            state_reg <= ref_active_reg ? REF : ACT;
`else
                            state_reg <= ACT;
`endif
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                    ACT: begin
                        cnt_reg   <= CW'(TRCD - 2);
                        state_reg <= WAIT_RCD;
                    end
                    WAIT_RCD: begin
                        if (cnt_reg == '0) begin
                            state_reg <= RDWR;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                    RDWR: begin
                        if (TCCD > 2) begin
                            cnt_reg   <= CW'((TCCD > 2) ? (TCCD - 3) : 0);
                            state_reg <= GAP;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                    GAP: begin
                        if (cnt_reg == '0) begin
                            state_reg <= IDLE;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
`ifdef CMD_SCHEDULER_REFRESH_EN
                    PREA: begin
                        cnt_reg   <= CW'(TRP - 2);
                        state_reg <= WAIT_RP;
                    end
                    REF: begin
                        cnt_reg   <= CW'(TRFC - 2);
                        state_reg <= WAIT_RFC;
                    end
                    WAIT_RFC: begin
                        if (cnt_reg == '0) begin
                            refresh_pending_reg <= 1'b0;
                            ref_active_reg      <= 1'b0;
                            state_reg           <= IDLE;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
`endif
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // Command states drive the bus only in a non-stalled cycle; all else is deselect.
    always_comb begin
        cs_n        = 1'b1;
        act_n       = 1'b1;
        A           = '0;
        bg          = '0;
        ba          = '0;
        rdwr_issued = 1'b0;
        rdwr_is_wr  = 1'b0;
        if (!stall) begin
            case (state_reg)
                ACT: begin
                    cs_n  = 1'b0;
                    act_n = 1'b0;
                    A     = row_reg;
                    bg    = bg_reg;
                    ba    = ba_reg;
                end
                PRE: begin
                    cs_n      = 1'b0;
                    A[16:14]  = CMD_PRE;
                    bg        = bg_reg;
                    ba        = ba_reg;
                end
                RDWR: begin
                    cs_n                 = 1'b0;
                    A[16:14]             = wr_reg ? CMD_WR : CMD_RD;
                    A[COLWIDTH-1:0]      = col_reg;
                    bg                   = bg_reg;
                    ba                   = ba_reg;
                    rdwr_issued          = 1'b1;
                    rdwr_is_wr           = wr_reg;
                end
`ifdef CMD_SCHEDULER_REFRESH_EN
                PREA: begin
                    cs_n     = 1'b0;
                    A[16:14] = CMD_PRE;
                    A[10]    = 1'b1;
                end
                REF: begin
                    cs_n     = 1'b0;
                    A[16:14] = CMD_REF;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
